// File: rtl/load_store_unit.sv
// Load/store unit: one memory operation at a time between the pipeline and a
// single-port data RAM, with RISC-V size/sign handling and an ack timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [1:0]  mem_ctrl,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StResp  = 2'd2;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        in_issue;

    function automatic logic req_ok(logic we, logic [2:0] f3, logic [1:0] lsb);
        logic legal;
        logic aligned;
        if (we) begin
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        end
        case (f3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~lsb[0];
            2'b10:   aligned = (lsb == 2'b00);
            default: aligned = 1'b0;
        endcase
        return legal & aligned;
    endfunction

    // Store data is replicated across lanes so the RAM only needs byte enables.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                st_be   = 4'b0001 << addr_q[1:0];
                st_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_be   = 4'b0011 << addr_q[1:0];
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = wdata_q;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    cnt_d    = 8'd0;
                    rdata_d  = 32'd0;
                    if (req_ok(req_we, req_funct3, req_addr[1:0])) begin
                        state_d = StIssue;
                        err_d   = 1'b0;
                    end else begin
                        state_d = StResp;
                        err_d   = 1'b1;
                    end
                end
            end
            StIssue: begin
                // Ack wins over an expiring counter in the same cycle.
                if (mem_ack) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : ld_data;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                err_d   = 1'b0;
                rdata_d = 32'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        in_issue   = (state_q == StIssue);
        req_ready  = (state_q == StIdle);
        busy       = ~req_ready;
        resp_valid = (state_q == StResp);
        resp_rdata = resp_valid ? rdata_q : 32'd0;
        resp_err   = resp_valid & err_q;
        mem_ctrl   = in_issue ? (we_q ? 2'b10 : 2'b01) : 2'b00;
        mem_addr   = in_issue ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_wdata  = (in_issue && we_q) ? st_data : 32'd0;
        mem_be     = (in_issue && we_q) ? st_be : 4'b0000;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum ISSUE cycles to wait for mem_ack before an error response; legal range 2..255.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous active-low reset; asserting low clears all state immediately.
REQ-004 req_valid  in  1  pipeline presents a memory operation.
REQ-005 req_ready  out  1  unit accepts a request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RISC-V size/sign field.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 resp_valid  out  1  one-cycle pulse completing the accepted request.
REQ-011 resp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-012 resp_err  out  1  qualifies resp_valid; misaligned, illegal funct3 or timeout.
REQ-013 busy  out  1  high in any state other than IDLE; drives pipeline stall.
REQ-014 mem_ctrl  out  2  data-RAM control: 00 idle, 01 read, 10 write.
REQ-015 mem_addr  out  32  word address = req_addr with bits [1:0] forced 0.
REQ-016 mem_wdata  out  32  store data shifted into byte lanes.
REQ-017 mem_be  out  4  byte enables for stores; 0000 for reads.
REQ-018 mem_rdata  in  32  word returned by RAM.
REQ-019 mem_ack  in  1  RAM completes the current access this cycle.

Function
REQ-020 FSM states IDLE, ISSUE, RESP; req_ready = 1 only in IDLE.
REQ-021 IDLE with req_valid=1 registers we/funct3/addr/wdata; legal aligned request -> ISSUE, else -> RESP with error flag set, no memory access.
REQ-022 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all others illegal.
REQ-023 Alignment: halfword needs addr[0]=0, word needs addr[1:0]=00; byte always aligned.
REQ-024 ISSUE drives mem_ctrl (01 load, 10 store), mem_addr, mem_wdata, mem_be stable every cycle until mem_ack; outside ISSUE mem_ctrl=00, mem_be=0000, mem_addr/mem_wdata=0.
REQ-025 Store lanes: SB be=0001<<addr[1:0], data byte replicated to all lanes; SH be=0011<<addr[1:0], halfword replicated twice; SW be=1111.
REQ-026 Load extraction: byte/half selected by addr[1:0] from mem_rdata sampled on the mem_ack cycle; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-027 ISSUE with mem_ack=1 -> RESP, err=0; minimum accept-to-resp_valid latency is 2 cycles (ack in first ISSUE cycle).
REQ-028 ISSUE wait counter clears on entry, increments each cycle without ack; ack absent for TIMEOUT cycles -> RESP with err=1, mem_ctrl returns to 00.
REQ-029 mem_ack ignored outside ISSUE; ack arriving in the same cycle the counter expires counts as success.
REQ-030 RESP asserts resp_valid for exactly one cycle, then IDLE; a new request is accepted no earlier than the cycle after RESP.
REQ-031 resp_rdata and resp_err hold their value only while resp_valid=1; otherwise 0.

Reset
REQ-032 rst low: state IDLE, counter 0, captured request cleared, all outputs 0 except req_ready=1.
REQ-033 Reset during ISSUE or RESP abandons the operation with no resp_valid; the first post-reset cycle is IDLE.

Verification
REQ-034 LW addr 0x100, RAM acks 1st ISSUE cycle with 0xDEADBEEF -> mem_ctrl=01, mem_addr=0x100, be=0000; resp_valid 2 cycles after accept, rdata 0xDEADBEEF, err 0.
REQ-035 LB/LBU addr 0x103, mem_rdata 0x80FF_1234 -> LB rdata 0xFFFFFF80, LBU rdata 0x00000080.
REQ-036 SH addr 0x202, wdata 0x0000ABCD -> mem_ctrl=10, mem_addr=0x200, be=1100, mem_wdata=0xABCDABCD; resp rdata 0, err 0.
REQ-037 LW addr 0x101, and funct3=011 -> no mem_ctrl activity, resp_valid next cycle with err=1.
REQ-038 LW with mem_ack never asserted, TIMEOUT=16 -> mem_ctrl=01 for 16 cycles, then resp_valid err=1, mem_ctrl=00.
REQ-039 rst low in 3rd ISSUE cycle -> outputs cleared asynchronously, no resp_valid, req_ready=1 after release.
